// File: rtl/mac_accumulator_serial_pkg.sv
// Shared types and width helpers for the mac_accumulator_serial slice.
// The sideband struct travels with the lanes through every adder-tree stage.
package mac_accum_pkg;

    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef struct packed {
        sel_t sel;
        logic neg;
        logic first;
        logic last;
        logic valid;
    } beat_ctrl_t;

    function automatic int tree_lg(input int vec_length);
        return $clog2(vec_length);
    endfunction

    function automatic int tree_stage_w(input int data_width, input int stage);
        return data_width + stage;
    endfunction

endpackage

// File: rtl/mac_accumulator_serial_if.sv
// Beat and result handshake bundle for mac_accumulator_serial.
// master = producer/consumer side, slave = the accumulator itself.
interface mac_accumulator_serial_if #(
    parameter int DATA_WIDTH  = 25,
    parameter int VEC_LENGTH  = 8,
    parameter int SHIFT_WIDTH = 3,
    parameter int ACC_WIDTH   = DATA_WIDTH + $clog2(VEC_LENGTH) + 2**SHIFT_WIDTH
);

    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  in_data [VEC_LENGTH];
    logic [SHIFT_WIDTH-1:0]        in_sel;
    logic                          in_neg;
    logic                          in_first;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   out_result;
    logic                          out_overflow;

    modport master (
        output in_valid, in_data, in_sel, in_neg, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_neg, in_first, in_last, out_ready,
        output in_ready, out_valid, out_result, out_overflow
    );

endinterface

// File: rtl/mac_accumulator_serial_tree.sv
// Registered pairwise adder tree: LG stages, stage k is DATA_WIDTH+k bits,
// with the beat sideband delayed alongside so it stays aligned to its sum.
module mac_adder_tree_pipe
    import mac_accum_pkg::*;
#(
    parameter  int DATA_WIDTH = 25,
    parameter  int VEC_LENGTH = 8,
    localparam int LG         = tree_lg(VEC_LENGTH),
    localparam int SUM_W      = tree_stage_w(DATA_WIDTH, LG)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] in_data [VEC_LENGTH],
    input  beat_ctrl_t                   in_ctrl,
    output logic signed [SUM_W-1:0]      sum,
    output beat_ctrl_t                   sum_ctrl
);

    for (genvar s = 1; s <= LG; s++) begin : g_stage
        localparam int W = tree_stage_w(DATA_WIDTH, s);
        localparam int N = VEC_LENGTH >> s;

        logic signed [W-1:0] node_d [N];
        logic signed [W-1:0] node_q [N];
        beat_ctrl_t          ctrl_d;
        beat_ctrl_t          ctrl_q;

        if (s == 1) begin : g_leaf
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node_d[i] = W'(in_data[2*i]) + W'(in_data[2*i+1]);
                end
                ctrl_d = in_ctrl;
            end
        end else begin : g_node
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node_d[i] = W'(g_stage[s-1].node_q[2*i]) + W'(g_stage[s-1].node_q[2*i+1]);
                end
                ctrl_d = g_stage[s-1].ctrl_q;
            end
        end

        // Stage boundary: only the sideband is reset; lane data just follows en.
        always_ff @(posedge clk) begin
            if (!reset) begin
                ctrl_q <= '0;
            end else if (en) begin
                ctrl_q <= ctrl_d;
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                node_q <= node_d;
            end
        end
    end

    assign sum      = g_stage[LG].node_q[0];
    assign sum_ctrl = g_stage[LG].ctrl_q;

endmodule

// File: rtl/mac_accumulator_serial.sv
// Bit-plane MAC accumulator: adder tree, per-beat shift/negate, group accumulate.
// Optional build macro MAC_ACCUM_SAT_EN enables saturation and out_overflow.
module mac_accumulator_serial
    import mac_accum_pkg::*;
#(
    parameter int DATA_WIDTH  = 25,
    parameter int VEC_LENGTH  = 8,
    parameter int SHIFT_WIDTH = 3,
    parameter int ACC_WIDTH   = DATA_WIDTH + $clog2(VEC_LENGTH) + 2**SHIFT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    mac_accumulator_serial_if.slave  bus
);

    localparam int LG    = tree_lg(VEC_LENGTH);
    localparam int SUM_W = tree_stage_w(DATA_WIDTH, LG);

    logic                        advance;
    beat_ctrl_t                  in_ctrl;
    beat_ctrl_t                  tree_ctrl;
    logic signed [SUM_W-1:0]     tree_sum;

    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
    logic signed [ACC_WIDTH-1:0] result_d, result_q;
    logic                        out_valid_d, out_valid_q;
    logic signed [ACC_WIDTH-1:0] next_acc;

    // A held result blocks the whole pipeline, so nothing in flight is lost.
    assign advance      = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = advance;

    always_comb begin
        in_ctrl       = '0;
        in_ctrl.sel   = sel_t'(bus.in_sel);
        in_ctrl.neg   = bus.in_neg;
        in_ctrl.first = bus.in_first;
        in_ctrl.last  = bus.in_last;
        in_ctrl.valid = bus.in_valid;
    end

    mac_adder_tree_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .en       (advance),
        .in_data  (bus.in_data),
        .in_ctrl  (in_ctrl),
        .sum      (tree_sum),
        .sum_ctrl (tree_ctrl)
    );

`ifdef MAC_ACCUM_SAT_EN
    // Wide enough for the fully shifted, negated term plus the accumulator.
    localparam int TERM_W = SUM_W + 2**SHIFT_WIDTH;
    localparam int WIDE_W = ((ACC_WIDTH > TERM_W) ? ACC_WIDTH : TERM_W) + 1;

    logic signed [WIDE_W-1:0]    term_w, base_w, next_w;
    logic [WIDE_W-ACC_WIDTH:0]   next_hi;
    logic                        ovf_now, sticky_nxt;
    logic                        sticky_d, sticky_q;
    logic                        ovf_d, ovf_q;

    always_comb begin
        term_w = WIDE_W'(tree_sum) <<< tree_ctrl.sel;
        if (tree_ctrl.neg) begin
            term_w = -term_w;
        end
        base_w     = tree_ctrl.first ? '0 : WIDE_W'(acc_q);
        next_w     = base_w + term_w;
        next_hi    = next_w[WIDE_W-1:ACC_WIDTH-1];
        ovf_now    = !((&next_hi) || !(|next_hi));
        sticky_nxt = (tree_ctrl.first ? 1'b0 : sticky_q) | ovf_now;
        if (!ovf_now) begin
            next_acc = next_w[ACC_WIDTH-1:0];
        end else if (next_w[WIDE_W-1]) begin
            next_acc = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            next_acc = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign bus.out_overflow = ovf_q;
`else
    logic signed [ACC_WIDTH-1:0] term_a, base_a;

    always_comb begin
        term_a = ACC_WIDTH'(tree_sum) <<< tree_ctrl.sel;
        if (tree_ctrl.neg) begin
            term_a = -term_a;
        end
        base_a   = tree_ctrl.first ? '0 : acc_q;
        next_acc = base_a + term_a;
    end

    assign bus.out_overflow = 1'b0;
`endif

    always_comb begin
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef MAC_ACCUM_SAT_EN
        sticky_d    = sticky_q;
        ovf_d       = ovf_q;
`endif
        if (advance) begin
            out_valid_d = 1'b0;
            if (tree_ctrl.valid) begin
                if (tree_ctrl.last) begin
                    result_d    = next_acc;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
`ifdef MAC_ACCUM_SAT_EN
                    ovf_d       = sticky_nxt;
                    sticky_d    = 1'b0;
`endif
                end else begin
                    acc_d = next_acc;
`ifdef MAC_ACCUM_SAT_EN
                    sticky_d = sticky_nxt;
`endif
                end
            end
        end
    end

    // Accumulate / output stage boundary.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef MAC_ACCUM_SAT_EN
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef MAC_ACCUM_SAT_EN
            sticky_q    <= sticky_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;

endmodule

// File: tb/tb_mac_accumulator_serial.sv
// Scoreboard bench for mac_accumulator_serial: directed bit-plane groups on a
// wide instance (ACC 18) and a narrow overflow instance (ACC 12).
module tb_mac_accumulator_serial;

    localparam int DW    = 8;
    localparam int VL    = 4;
    localparam int SW    = 3;
    localparam int ACC_A = DW + 2 + 8;
    localparam int ACC_B = 12;
`ifdef MAC_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_accumulator_serial_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW), .ACC_WIDTH(ACC_A)) a ();
    mac_accumulator_serial_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW), .ACC_WIDTH(ACC_B)) b ();

    mac_accumulator_serial #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW), .ACC_WIDTH(ACC_A)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    mac_accumulator_serial #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SHIFT_WIDTH(SW), .ACC_WIDTH(ACC_B)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop the next expected result on every accepted output.
    always @(negedge clk) begin
        if (reset && a.out_valid && a.out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected: got result %0d, expected no output", longint'(a.out_result));
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_result", longint'(a.out_result), e.res);
                check("a_overflow", longint'(a.out_overflow), longint'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && b.out_valid && b.out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected: got result %0d, expected no output", longint'(b.out_result));
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_result", longint'(b.out_result), e.res);
                check("b_overflow", longint'(b.out_overflow), longint'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input bit to_b, input int l0, input int l1, input int l2, input int l3,
                        input int sel, input bit neg, input bit first, input bit last);
        int lanes [4];
        int waited;
        lanes  = '{l0, l1, l2, l3};
        waited = 0;
        if (to_b) begin
            for (int i = 0; i < 4; i++) b.in_data[i] = DW'(lanes[i]);
            b.in_sel = SW'(sel); b.in_neg = neg; b.in_first = first; b.in_last = last;
            b.in_valid = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) a.in_data[i] = DW'(lanes[i]);
            a.in_sel = SW'(sel); a.in_neg = neg; a.in_first = first; a.in_last = last;
            a.in_valid = 1'b1;
        end
        while (!(to_b ? b.in_ready : a.in_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", waited);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        a.in_valid = 1'b0;
        b.in_valid = 1'b0;
    endtask

    task automatic push_a(input longint res);
        exp_t e;
        e.res = res;
        e.ovf = 1'b0;
        qa.push_back(e);
    endtask

    task automatic push_b(input longint res, input bit ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        qb.push_back(e);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", longint'(qa.size() + qb.size()), 0);
    endtask

    initial begin
        a.in_valid = 1'b0; a.in_sel = '0; a.in_neg = 1'b0; a.in_first = 1'b0; a.in_last = 1'b0;
        b.in_valid = 1'b0; b.in_sel = '0; b.in_neg = 1'b0; b.in_first = 1'b0; b.in_last = 1'b0;
        for (int i = 0; i < VL; i++) begin
            a.in_data[i] = '0;
            b.in_data[i] = '0;
        end
        a.out_ready = 1'b1;
        b.out_ready = 1'b1;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(a.out_valid), 0);
        check("rst_out_result", longint'(a.out_result), 0);
        check("rst_out_overflow", longint'(a.out_overflow), 0);
        check("rst_in_ready", longint'(a.in_ready), 1);
        check("rst_b_out_valid", longint'(b.out_valid), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single beat, first=last: 1+2+3+4, valid three cycles after acceptance.
        push_a(10);
        send(0, 1, 2, 3, 4, 0, 0, 1, 1);
        check("lat_not_early", longint'(a.out_valid), 0);
        @(negedge clk);
        check("lat_still_low", longint'(a.out_valid), 0);
        @(negedge clk);
        check("lat_valid", longint'(a.out_valid), 1);
        @(negedge clk);
        check("valid_drops", longint'(a.out_valid), 0);

        // Four planes of ones with a negative MSB plane: 4+8+16-32.
        push_a(-4);
        send(0, 1, 1, 1, 1, 0, 0, 1, 0);
        send(0, 1, 1, 1, 1, 1, 0, 0, 0);
        send(0, 1, 1, 1, 1, 2, 0, 0, 0);
        send(0, 1, 1, 1, 1, 3, 1, 0, 1);

        // Beat without first after a finished group starts from 0.
        push_a(4);
        send(0, 1, 1, 1, 1, 0, 0, 1, 1);
        push_a(8);
        send(0, 2, 2, 2, 2, 0, 0, 0, 1);

        // first mid-group drops the 28 already accumulated.
        push_a(4);
        send(0, 7, 7, 7, 7, 0, 0, 1, 0);
        send(0, 1, 1, 1, 1, 0, 0, 1, 1);

        // Signed lanes, mixed shifts: -3*4<<2 = -48, then -(1+2+3+4) = -58.
        push_a(-58);
        send(0, -3, -3, -3, -3, 2, 0, 1, 0);
        send(0, 1, 2, 3, 4, 0, 1, 0, 1);
        wait_drain();

        // Backpressure: results 20, -58, 4 must come out in order.
        @(posedge clk);
        #1 a.out_ready = 1'b0;
        @(negedge clk);
        push_a(20);
        push_a(-58);
        push_a(4);
        fork
            begin
                send(0, 1, 1, 1, 1, 0, 0, 1, 0);
                send(0, 2, 2, 2, 2, 1, 0, 0, 1);
                send(0, -3, -3, -3, -3, 2, 0, 1, 0);
                send(0, 1, 2, 3, 4, 0, 1, 0, 1);
                send(0, 1, 1, 1, 1, 0, 0, 1, 1);
            end
            begin
                int k;
                k = 0;
                while (!a.out_valid && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("stall_valid_seen", longint'(a.out_valid), 1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", longint'(a.in_ready), 0);
                    check("stall_result_hold", longint'(a.out_result), 20);
                end
                @(posedge clk);
                #1 a.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-group, then a last-only beat must not see the old partial sum.
        send(0, 9, 9, 9, 9, 2, 0, 1, 0);
        send(0, 1, 1, 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_out_valid", longint'(a.out_valid), 0);
        check("mid_rst_out_result", longint'(a.out_result), 0);
        reset = 1'b1;
        @(negedge clk);
        push_a(4);
        send(0, 1, 1, 1, 1, 0, 0, 0, 1);
        push_a(40);
        send(0, 5, 5, 5, 5, 1, 0, 1, 1);
        wait_drain();

        // Narrow accumulator: wrap vs. clamp.
        push_b(SAT ? 2047 : -32, SAT);
        send(1, 127, 127, 127, 127, 3, 0, 1, 1);
        push_b(SAT ? -2048 : 0, SAT);
        send(1, -128, -128, -128, -128, 3, 0, 1, 1);
        push_b(SAT ? 2043 : -36, SAT);
        send(1, 127, 127, 127, 127, 3, 0, 1, 0);
        send(1, -1, -1, -1, -1, 0, 0, 0, 1);
        push_b(4, 1'b0);
        send(1, 1, 1, 1, 1, 0, 0, 1, 1);
        wait_drain();

        // Same -4 group with idle bubbles between the beats.
        push_a(-4);
        send(0, 1, 1, 1, 1, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        send(0, 1, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        send(0, 1, 1, 1, 1, 2, 0, 0, 0);
        repeat (3) @(negedge clk);
        send(0, 1, 1, 1, 1, 3, 1, 0, 1);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
